memory_stage: RTL and testbench

Memory (MEM) stage of the 5-stage pipeline, between execute and writeback. It registers the execute-stage results, performs data-memory loads and stores (word and byte) against an internal data RAM, and drives memory-mapped HEX/LEDR/LEDG output registers. Its registered outputs feed the writeback stage directly: opcode, ALU result, load data, destination index and stall flags.

---
 rtl/memory_stage_pkg.sv | 26 ++
 rtl/memory_stage_if.sv | 31 +++
 rtl/memory_stage_dmem_ram.sv | 21 ++
 rtl/memory_stage.sv | 119 +++++++++++
 tb/tb_memory_stage.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/memory_stage_pkg.sv
// Shared definitions for the MEM stage: widths, memory opcodes, MMIO map.
package memory_stage_pkg;
  localparam int OPCODE_WIDTH = 8;
  localparam int REG_WIDTH    = 16;

  localparam logic [OPCODE_WIDTH-1:0] OP_LDW = 8'h50;
  localparam logic [OPCODE_WIDTH-1:0] OP_STW = 8'h51;
  localparam logic [OPCODE_WIDTH-1:0] OP_LDB = 8'h52;
  localparam logic [OPCODE_WIDTH-1:0] OP_STB = 8'h53;

  localparam logic [15:0] ADDR_HEX  = 16'hFFF0;
  localparam logic [15:0] ADDR_LEDR = 16'hFFF2;
  localparam logic [15:0] ADDR_LEDG = 16'hFFF4;

  typedef enum logic [1:0] {MM_NONE, MM_HEX, MM_LEDR, MM_LEDG} mmio_sel_e;

  // MMIO registers are word-sized; bit 0 of the byte address is not decoded.
  function automatic mmio_sel_e mmio_decode(input logic [15:0] addr);
    mmio_sel_e s;
    s = MM_NONE;
    if (addr[15:1] == ADDR_HEX[15:1])  s = MM_HEX;
    if (addr[15:1] == ADDR_LEDR[15:1]) s = MM_LEDR;
    if (addr[15:1] == ADDR_LEDG[15:1]) s = MM_LEDG;
    return s;
  endfunction
endpackage

// File: rtl/memory_stage_if.sv
// Execute -> MEM -> writeback signal bundle.
interface memory_stage_if;
  import memory_stage_pkg::*;
  logic [OPCODE_WIDTH-1:0] I_Opcode;
  logic [REG_WIDTH-1:0]    I_ALUOut;
  logic [REG_WIDTH-1:0]    I_StoreData;
  logic [3:0]              I_DestRegIdx;
  logic                    I_FetchStall;
  logic                    I_DepStall;
  logic                    I_LOCK;
  logic [OPCODE_WIDTH-1:0] O_Opcode;
  logic [REG_WIDTH-1:0]    O_ALUOut;
  logic [REG_WIDTH-1:0]    O_MemOut;
  logic [3:0]              O_DestRegIdx;
  logic                    O_FetchStall;
  logic                    O_DepStall;
  logic [15:0]             O_HEX;
  logic [9:0]              O_LEDR;
  logic [7:0]              O_LEDG;

  modport master (
    output I_Opcode, I_ALUOut, I_StoreData, I_DestRegIdx, I_FetchStall, I_DepStall, I_LOCK,
    input  O_Opcode, O_ALUOut, O_MemOut, O_DestRegIdx, O_FetchStall, O_DepStall,
           O_HEX, O_LEDR, O_LEDG
  );
  modport slave (
    input  I_Opcode, I_ALUOut, I_StoreData, I_DestRegIdx, I_FetchStall, I_DepStall, I_LOCK,
    output O_Opcode, O_ALUOut, O_MemOut, O_DestRegIdx, O_FetchStall, O_DepStall,
           O_HEX, O_LEDR, O_LEDG
  );
endinterface

// File: rtl/memory_stage_dmem_ram.sv
// Data RAM: 16-bit words, asynchronous read, per-byte synchronous write.
module dmem_ram #(
  parameter int DMEM_WORDS = 1024,
  localparam int AW = $clog2(DMEM_WORDS)
) (
  input  logic          clk_i,
  input  logic [AW-1:0] addr_i,
  input  logic [1:0]    we_i,
  input  logic [15:0]   wdata_i,
  output logic [15:0]   rdata_o
);
  logic [15:0] mem_q [DMEM_WORDS];

  assign rdata_o = mem_q[addr_i];

  // Byte-lane writes; contents are intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (we_i[0]) mem_q[addr_i][7:0]  <= wdata_i[7:0];
    if (we_i[1]) mem_q[addr_i][15:8] <= wdata_i[15:8];
  end
endmodule

// File: rtl/memory_stage.sv
// MEM pipeline stage: load/store against data RAM, MMIO LED/HEX registers,
// and the registers feeding writeback.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int DMEM_WORDS = 1024
) (
  input logic           I_CLOCK,
  input logic           I_RESETN,
  memory_stage_if.slave bus
);
  localparam int AW = $clog2(DMEM_WORDS);

  logic                    valid;
  logic                    in_ram;
  mmio_sel_e               msel;
  logic [AW-1:0]           widx;
  logic [15:0]             rdata;
  logic [1:0]              we;
  logic [15:0]             wdata;
  logic [REG_WIDTH-1:0]    mem_d, mem_q;
  logic [15:0]             hex_d, hex_q;
  logic [9:0]              ledr_d, ledr_q;
  logic [7:0]              ledg_d, ledg_q;
  logic [OPCODE_WIDTH-1:0] op_q;
  logic [REG_WIDTH-1:0]    alu_q;
  logic [3:0]              dst_q;
  logic                    fs_q, ds_q;

  assign valid  = bus.I_LOCK & ~bus.I_FetchStall & ~bus.I_DepStall;
  assign in_ram = 32'(bus.I_ALUOut) < 32'(2 * DMEM_WORDS);
  assign msel   = mmio_decode(bus.I_ALUOut);
  assign widx   = bus.I_ALUOut[AW:1];

  // A store seen while reset is low must not reach the RAM.
  dmem_ram #(.DMEM_WORDS(DMEM_WORDS)) u_ram (
    .clk_i   (I_CLOCK),
    .addr_i  (widx),
    .we_i    (we & {2{I_RESETN}}),
    .wdata_i (wdata),
    .rdata_o (rdata)
  );

  // Address decode, load data selection and store/MMIO write steering.
  always_comb begin
    we     = 2'b00;
    wdata  = bus.I_StoreData;
    mem_d  = '0;
    hex_d  = hex_q;
    ledr_d = ledr_q;
    ledg_d = ledg_q;
    if (valid) begin
      case (bus.I_Opcode)
        OP_LDW: begin
          case (msel)
            MM_HEX:  mem_d = hex_q;
            MM_LEDR: mem_d = {6'b0, ledr_q};
            MM_LEDG: mem_d = {8'b0, ledg_q};
            MM_NONE: if (in_ram) mem_d = rdata;
          endcase
        end
        OP_LDB: begin
          if (msel == MM_NONE && in_ram)
            mem_d = bus.I_ALUOut[0] ? {8'b0, rdata[15:8]} : {8'b0, rdata[7:0]};
        end
        OP_STW: begin
          case (msel)
            MM_HEX:  hex_d  = bus.I_StoreData;
            MM_LEDR: ledr_d = bus.I_StoreData[9:0];
            MM_LEDG: ledg_d = bus.I_StoreData[7:0];
            MM_NONE: if (in_ram) we = 2'b11;
          endcase
        end
        OP_STB: begin
          if (msel == MM_NONE && in_ram) begin
            we    = bus.I_ALUOut[0] ? 2'b10 : 2'b01;
            wdata = {2{bus.I_StoreData[7:0]}};
          end
        end
        default: ;
      endcase
    end
  end

  // Pipeline and MMIO registers; everything freezes while I_LOCK is low.
  always_ff @(posedge I_CLOCK or negedge I_RESETN) begin
    if (!I_RESETN) begin
      op_q   <= '0;
      alu_q  <= '0;
      mem_q  <= '0;
      dst_q  <= '0;
      fs_q   <= 1'b0;
      ds_q   <= 1'b0;
      hex_q  <= '0;
      ledr_q <= '0;
      ledg_q <= '0;
    end else if (bus.I_LOCK) begin
      op_q   <= bus.I_Opcode;
      alu_q  <= bus.I_ALUOut;
      mem_q  <= mem_d;
      dst_q  <= bus.I_DestRegIdx;
      fs_q   <= bus.I_FetchStall;
      ds_q   <= bus.I_DepStall;
      hex_q  <= hex_d;
      ledr_q <= ledr_d;
      ledg_q <= ledg_d;
    end
  end

  assign bus.O_Opcode     = op_q;
  assign bus.O_ALUOut     = alu_q;
  assign bus.O_MemOut     = mem_q;
  assign bus.O_DestRegIdx = dst_q;
  assign bus.O_FetchStall = fs_q;
  assign bus.O_DepStall   = ds_q;
  assign bus.O_HEX        = hex_q;
  assign bus.O_LEDR       = ledr_q;
  assign bus.O_LEDG       = ledg_q;
endmodule

// File: tb/tb_memory_stage.sv
// Randomized + directed bench for memory_stage against a byte-array model.
module tb_memory_stage;
  import memory_stage_pkg::*;

  logic gclk = 1'b0;
  logic grst_n = 1'b0;
  always #5 gclk = ~gclk;

  memory_stage_if bus();

  memory_stage #(.DMEM_WORDS(1024)) dut (
    .I_CLOCK  (gclk),
    .I_RESETN (grst_n),
    .bus      (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference state: byte-addressed memory plus expected registered outputs.
  logic [7:0]  mbytes [0:2047];
  logic [7:0]  e_op;
  logic [15:0] e_alu, e_mem, e_hex;
  logic [3:0]  e_dst;
  logic        e_fs, e_ds;
  logic [9:0]  e_ledr;
  logic [7:0]  e_ledg;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    e_op = '0; e_alu = '0; e_mem = '0; e_dst = '0; e_fs = 0; e_ds = 0;
    e_hex = '0; e_ledr = '0; e_ledg = '0;
  endtask

  // One clock edge worth of architectural behaviour, from current inputs.
  task automatic model_edge();
    int a;
    logic mm_hex, mm_ledr, mm_ledg, ram;
    if (!grst_n) begin model_reset(); return; end
    if (!bus.I_LOCK) return;
    a       = int'(bus.I_ALUOut);
    mm_hex  = (a / 2) == (int'(ADDR_HEX) / 2);
    mm_ledr = (a / 2) == (int'(ADDR_LEDR) / 2);
    mm_ledg = (a / 2) == (int'(ADDR_LEDG) / 2);
    ram     = a < 2048;
    e_op = bus.I_Opcode; e_alu = bus.I_ALUOut; e_dst = bus.I_DestRegIdx;
    e_fs = bus.I_FetchStall; e_ds = bus.I_DepStall; e_mem = '0;
    if (bus.I_FetchStall || bus.I_DepStall) return;
    if (bus.I_Opcode == OP_LDW) begin
      if (mm_hex) e_mem = e_hex;
      else if (mm_ledr) e_mem = 16'(e_ledr);
      else if (mm_ledg) e_mem = 16'(e_ledg);
      else if (ram) e_mem = {mbytes[a - a % 2 + 1], mbytes[a - a % 2]};
    end else if (bus.I_Opcode == OP_LDB) begin
      if (ram) e_mem = 16'(mbytes[a]);
    end else if (bus.I_Opcode == OP_STW) begin
      if (mm_hex) e_hex = bus.I_StoreData;
      else if (mm_ledr) e_ledr = bus.I_StoreData[9:0];
      else if (mm_ledg) e_ledg = bus.I_StoreData[7:0];
      else if (ram) begin
        mbytes[a - a % 2]     = bus.I_StoreData[7:0];
        mbytes[a - a % 2 + 1] = bus.I_StoreData[15:8];
      end
    end else if (bus.I_Opcode == OP_STB) begin
      if (ram) mbytes[a] = bus.I_StoreData[7:0];
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".op"},   32'(bus.O_Opcode),     32'(e_op));
    chk({tag, ".alu"},  32'(bus.O_ALUOut),     32'(e_alu));
    chk({tag, ".mem"},  32'(bus.O_MemOut),     32'(e_mem));
    chk({tag, ".dst"},  32'(bus.O_DestRegIdx), 32'(e_dst));
    chk({tag, ".fs"},   32'(bus.O_FetchStall), 32'(e_fs));
    chk({tag, ".ds"},   32'(bus.O_DepStall),   32'(e_ds));
    chk({tag, ".hex"},  32'(bus.O_HEX),        32'(e_hex));
    chk({tag, ".ledr"}, 32'(bus.O_LEDR),       32'(e_ledr));
    chk({tag, ".ledg"}, 32'(bus.O_LEDG),       32'(e_ledg));
  endtask

  task automatic drv(input logic [7:0] op, input logic [15:0] alu, input logic [15:0] sd,
                     input logic [3:0] dst, input logic fs = 0, input logic ds = 0,
                     input logic lk = 1);
    bus.I_Opcode = op; bus.I_ALUOut = alu; bus.I_StoreData = sd;
    bus.I_DestRegIdx = dst; bus.I_FetchStall = fs; bus.I_DepStall = ds; bus.I_LOCK = lk;
  endtask

  task automatic cyc(input string tag);
    model_edge();
    @(posedge gclk);
    #1;
    check_all(tag);
  endtask

  logic [15:0] pool [13] = '{16'h0000, 16'h0001, 16'h0010, 16'h0011, 16'h0020, 16'h0021,
                             16'h002E, 16'hFFF0, 16'hFFF2, 16'hFFF3, 16'hFFF4, 16'h0800,
                             16'h0801};
  logic [7:0]  ops  [7]  = '{OP_LDW, OP_STW, OP_LDB, OP_STB, 8'h00, 8'h10, 8'h22};

  initial begin
    for (int i = 0; i < 2048; i++) mbytes[i] = '0;
    model_reset();
    drv(8'h00, 16'h0, 16'h0, 4'h0);
    repeat (2) @(posedge gclk);
    #1 check_all("rst");
    @(negedge gclk) grst_n = 1'b1;

    // Give every word the random stream can touch a known value.
    for (int w = 0; w <= 16'h2E; w += 2) begin
      drv(OP_STW, 16'(w), 16'($urandom), 4'h0);
      cyc("pre");
    end

    drv(OP_STW, 16'h0010, 16'hBEEF, 4'h3); cyc("st");
    drv(OP_LDW, 16'h0010, 16'h0, 4'h5);    cyc("rt");
    chk("rt.beef", 32'(bus.O_MemOut), 32'hBEEF);
    chk("rt.dst", 32'(bus.O_DestRegIdx), 32'h5);

    drv(OP_STW, 16'h0020, 16'h1234, 4'h1); cyc("bl0");
    drv(OP_STB, 16'h0021, 16'h77AB, 4'h1); cyc("bl1");
    drv(OP_LDW, 16'h0020, 16'h0, 4'h2);    cyc("bl2");
    chk("bl.ldw", 32'(bus.O_MemOut), 32'hAB34);
    drv(OP_LDB, 16'h0020, 16'h0, 4'h2);    cyc("bl3");
    chk("bl.ldb0", 32'(bus.O_MemOut), 32'h0034);
    drv(OP_LDB, 16'h0021, 16'h0, 4'h2);    cyc("bl4");
    chk("bl.ldb1", 32'(bus.O_MemOut), 32'h00AB);

    drv(OP_STW, ADDR_HEX,  16'h0C3F, 4'h0); cyc("mm0");
    drv(OP_STW, ADDR_LEDR, 16'h03FF, 4'h0); cyc("mm1");
    drv(OP_STW, ADDR_LEDG, 16'hFFA5, 4'h0); cyc("mm2");
    chk("mm.hex", 32'(bus.O_HEX), 32'h0C3F);
    chk("mm.ledr", 32'(bus.O_LEDR), 32'h3FF);
    chk("mm.ledg", 32'(bus.O_LEDG), 32'hA5);
    drv(OP_LDW, ADDR_LEDG, 16'h0, 4'h0);    cyc("mm3");
    chk("mm.ldledg", 32'(bus.O_MemOut), 32'h00A5);

    drv(OP_STW, 16'h0010, 16'h1111, 4'h0, 0, 1); cyc("bub0");
    chk("bub.ds", 32'(bus.O_DepStall), 32'h1);
    drv(OP_STW, 16'h0010, 16'h2222, 4'h9, 0, 0, 0);
    repeat (3) cyc("lock");
    chk("lock.dst", 32'(bus.O_DestRegIdx), 32'h0);
    drv(OP_LDW, 16'h0010, 16'h0, 4'h0);    cyc("bub1");
    chk("bub.ram", 32'(bus.O_MemOut), 32'hBEEF);

    drv(OP_STW, 16'h0800, 16'h9999, 4'h0); cyc("rng0");
    drv(OP_LDW, 16'h0800, 16'h0, 4'h0);    cyc("rng1");
    chk("rng.ld", 32'(bus.O_MemOut), 32'h0);
    drv(OP_LDW, 16'h0000, 16'h0, 4'h0);    cyc("rng2");
    chk("rng.alias", 32'(bus.O_MemOut), {16'h0, mbytes[1], mbytes[0]});

    // Reset mid-stream with a store pending; it must not commit.
    drv(OP_STW, 16'h0020, 16'h5555, 4'h4);
    #2 grst_n = 1'b0;
    model_reset();
    #1 check_all("rmid");
    @(posedge gclk);
    #1 check_all("rmid2");
    grst_n = 1'b1;
    drv(OP_LDW, 16'h0020, 16'h0, 4'h4);    cyc("rmid3");
    chk("rmid.ram", 32'(bus.O_MemOut), 32'hAB34);

    for (int n = 0; n < 400; n++) begin
      drv(ops[$urandom_range(6)], pool[$urandom_range(12)], 16'($urandom),
          4'($urandom), ($urandom_range(7) == 0), ($urandom_range(7) == 0),
          ($urandom_range(7) != 0));
      cyc("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
